// File: rtl/decode_if.sv
// Decoder bus: instruction word in, registered decoded fields out.
// The master presents instructions; the decoder (slave) drives the decoded side.
interface decode_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        is_muldiv;
    logic        illegal;
    logic        out_valid;

    modport master (
        output instr_valid, instr,
        input  opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, is_muldiv, illegal, out_valid
    );

    modport slave (
        input  instr_valid, instr,
        output opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, is_muldiv, illegal, out_valid
    );
endinterface

// File: rtl/decode.sv
// RV32IM instruction decoder: field slicing, immediate build, format class and
// illegal-encoding flag, all registered one cycle after an accepted instruction.
module decode (
    input  logic   clk,
    input  logic   rst_n,
    decode_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;

    logic [31:0] i;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  nfmt;
    logic [31:0] nimm;
    logic        nill;
    logic        nmd;

    assign i  = bus.instr;
    assign op = i[6:0];
    assign f3 = i[14:12];
    assign f7 = i[31:25];

    always_comb begin
        nfmt = FMT_UNK;
        unique case (op)
            7'b0110011:                                         nfmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                             nfmt = FMT_I;
            7'b0100011:                                         nfmt = FMT_S;
            7'b1100011:                                         nfmt = FMT_B;
            7'b0110111, 7'b0010111:                             nfmt = FMT_U;
            7'b1101111:                                         nfmt = FMT_J;
            default:                                            nfmt = FMT_UNK;
        endcase
    end

    always_comb begin
        nimm = '0;
        case (nfmt)
            FMT_I:   nimm = {{20{i[31]}}, i[31:20]};
            FMT_S:   nimm = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   nimm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   nimm = {i[31:12], 12'b0};
            FMT_J:   nimm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: nimm = '0;
        endcase
    end

    always_comb begin
        nmd  = (op == 7'b0110011) && (f7 == 7'b0000001);
        nill = 1'b0;
        case (op)
            7'b0110011: begin
                if (f7 != 7'b0000000 && f7 != 7'b0100000 && f7 != 7'b0000001)
                    nill = 1'b1;
                if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
                    nill = 1'b1;
            end
            // Only shift-immediates constrain the upper bits of OP-IMM.
            7'b0010011: begin
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    nill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    nill = 1'b1;
            end
            7'b1100011: nill = (f3 == 3'b010) || (f3 == 3'b011);
            7'b0000011: nill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            7'b0100011: nill = (f3 >= 3'b011);
            7'b1100111: nill = (f3 != 3'b000);
            default:    nill = (nfmt == FMT_UNK);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.opcode    <= '0;
            bus.rd        <= '0;
            bus.funct3    <= '0;
            bus.rs1       <= '0;
            bus.rs2       <= '0;
            bus.funct7    <= '0;
            bus.imm       <= '0;
            bus.fmt       <= '0;
            bus.is_muldiv <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.instr_valid;
            if (bus.instr_valid) begin
                bus.opcode    <= op;
                bus.rd        <= i[11:7];
                bus.funct3    <= f3;
                bus.rs1       <= i[19:15];
                bus.rs2       <= i[24:20];
                bus.funct7    <= f7;
                bus.imm       <= nimm;
                bus.fmt       <= nfmt;
                bus.is_muldiv <= nmd;
                bus.illegal   <= nill;
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: known encodings with fixed expectations, then
// random traffic against a reference model, plus hold and async reset checks.
module tb_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_if dif ();
    decode u_dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        md;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    exp_t last;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '0;
        f3 = x[14:12];
        f7 = x[31:25];
        e.valid = 1'b1;
        e.opcode = x[6:0]; e.rd = x[11:7]; e.funct3 = f3;
        e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.funct7 = f7;
        e.fmt = 3'd7;
        e.ill = 1'b0;
        case (x[6:0])
            7'h33: begin
                e.fmt = 3'd0;
                e.md = (f7 == 7'h01);
                e.ill = !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) ||
                        (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
            end
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0f: begin
                e.fmt = 3'd1;
                e.imm = 32'($signed(x) >>> 20);
                if (x[6:0] == 7'h13)
                    e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
                if (x[6:0] == 7'h03) e.ill = (f3 == 3'd3 || f3 >= 3'd6);
                if (x[6:0] == 7'h67) e.ill = (f3 != 3'd0);
            end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = (32'($signed(x) >>> 20) & ~32'h1f) | {27'd0, x[11:7]};
                e.ill = (f3 > 3'd2);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
                e.ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = x & 32'hffff_f000;
            end
            7'h6f: begin
                e.fmt = 3'd5;
                e.imm = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic compare_out(input exp_t e, input string pfx);
        check({pfx, ".out_valid"}, 32'(dif.out_valid), 32'(e.valid));
        check({pfx, ".opcode"},    32'(dif.opcode),    32'(e.opcode));
        check({pfx, ".rd"},        32'(dif.rd),        32'(e.rd));
        check({pfx, ".funct3"},    32'(dif.funct3),    32'(e.funct3));
        check({pfx, ".rs1"},       32'(dif.rs1),       32'(e.rs1));
        check({pfx, ".rs2"},       32'(dif.rs2),       32'(e.rs2));
        check({pfx, ".funct7"},    32'(dif.funct7),    32'(e.funct7));
        check({pfx, ".imm"},       dif.imm,            e.imm);
        check({pfx, ".fmt"},       32'(dif.fmt),       32'(e.fmt));
        check({pfx, ".is_muldiv"}, 32'(dif.is_muldiv), 32'(e.md));
        check({pfx, ".illegal"},   32'(dif.illegal),   32'(e.ill));
    endtask

    // Drive on the falling edge, push the expectation, compare 1 ns after the rising edge.
    task automatic step(input logic v, input logic [31:0] x, input exp_t e, input string pfx);
        exp_t got_e;
        @(negedge clk);
        dif.instr_valid = v;
        dif.instr = x;
        if (v) last = e;
        got_e = last;
        got_e.valid = v;
        sbq.push_back(got_e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", pfx);
        end else
            compare_out(sbq.pop_front(), pfx);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        md;
        logic        ill;
    } vec_t;

    vec_t vecs[12] = '{
        '{32'h002081b3, 32'h00000000, 3'd0, 1'b0, 1'b0},
        '{32'h00a00113, 32'h0000000a, 3'd1, 1'b0, 1'b0},
        '{32'hfff00113, 32'hffffffff, 3'd1, 1'b0, 1'b0},
        '{32'h00512023, 32'h00000000, 3'd2, 1'b0, 1'b0},
        '{32'h00208663, 32'h0000000c, 3'd3, 1'b0, 1'b0},
        '{32'hfe208ee3, 32'hfffffffc, 3'd3, 1'b0, 1'b0},
        '{32'h123450b7, 32'h12345000, 3'd4, 1'b0, 1'b0},
        '{32'h004000ef, 32'h00000004, 3'd5, 1'b0, 1'b0},
        '{32'hffdff0ef, 32'hfffffffc, 3'd5, 1'b0, 1'b0},
        '{32'h022081b3, 32'h00000000, 3'd0, 1'b1, 1'b0},
        '{32'h0000007f, 32'h00000000, 3'd7, 1'b0, 1'b1},
        '{32'h402091b3, 32'h00000000, 3'd0, 1'b0, 1'b1}
    };

    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0f,
                            7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] x;
        last = '0;
        dif.instr_valid = 1'b0;
        dif.instr = '0;
        #12;
        compare_out('0, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            e = model(vecs[k].ins);
            e.imm = vecs[k].imm;
            e.fmt = vecs[k].fmt;
            e.md  = vecs[k].md;
            e.ill = vecs[k].ill;
            step(1'b1, vecs[k].ins, e, $sformatf("vec%0d", k));
        end
        // ADD fields against literal values, independent of the model
        step(1'b1, 32'h002081b3, model(32'h002081b3), "add");
        check("add.rd_lit", 32'(dif.rd), 32'd3);
        check("add.rs2_lit", 32'(dif.rs2), 32'd2);
        step(1'b0, 32'hdeadbeef, '0, "hold");

        for (int n = 0; n < 300; n++) begin
            x = $urandom;
            if ($urandom_range(0, 3) != 0) x[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h01;
            step($urandom_range(0, 4) != 0, x, model(x), $sformatf("rnd%0d", n));
        end

        step(1'b1, 32'hfe208ee3, model(32'hfe208ee3), "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        compare_out('0, "async_rst");
        last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h123450b7, model(32'h123450b7), "post_rst");
        step(1'b1, 32'h022081b3, model(32'h022081b3), "post_rst_mul");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode.md
# decode

RV32IM instruction decoder for the single-cycle CPU datapath. It splits a 32-bit instruction into opcode, register indices and function fields. It also builds the sign-extended immediate for the instruction's format, classifies the format, and flags illegal encodings. All outputs are registered, with a one-cycle pipeline stage between fetch and register-file/ALU control.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  `instr` is valid this cycle.
- instr  in  32  raw instruction word.
- opcode  out  7  `instr[6:0]`.
- rd  out  5  `instr[11:7]`.
- funct3  out  3  `instr[14:12]`.
- rs1  out  5  `instr[19:15]`.
- rs2  out  5  `instr[24:20]`.
- funct7  out  7  `instr[31:25]`.
- imm  out  32  sign-extended immediate for the decoded format.
- fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- is_muldiv  out  1  M-extension instruction (opcode 0110011, funct7 0000001).
- illegal  out  1  encoding is not a legal RV32IM instruction.
- out_valid  out  1  the registered outputs correspond to an accepted instruction.

## Operation
- Field slices (`opcode`, `rd`, `funct3`, `rs1`, `rs2`, `funct7`) are always raw bit extractions, regardless of format.
- Format is selected by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - anything else: `fmt`=7.
- Immediate construction by format (sign bit is always `instr[31]`):
  - I: `{{20{i[31]}}, i[31:20]}`.
  - S: `{{20{i[31]}}, i[31:25], i[11:7]}`.
  - B: `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}`.
  - U: `{i[31:12], 12'b0}`.
  - J: `{{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}`.
  - R and unknown: 0.
- `illegal`=1 in each of these cases:
  - `fmt`=7;
  - R-type with `funct7` not in {0000000, 0100000, 0000001};
  - R-type with `funct7`=0100000 and `funct3` not in {000, 101};
  - OP-IMM shifts: `funct3`=001 with `funct7`≠0000000, or `funct3`=101 with `funct7` not in {0000000, 0100000};
  - branch with `funct3` in {010, 011};
  - load with `funct3` in {011, 110, 111};
  - store with `funct3` ≥ 011;
  - JALR with `funct3`≠000.
- `is_muldiv` is 1 only for opcode 0110011 with `funct7`=0000001.

## Timing
- Reset (`rst_n` low, asynchronous): every output is 0. This includes `out_valid`, `illegal`, `imm`, and `fmt`=0.
- Latency is one cycle. When `instr_valid`=1 at edge N, all decoded outputs reflect that `instr` after edge N, and `out_valid`=1.
- When `instr_valid`=0 at an edge:
  - decoded outputs hold their previous values;
  - `out_valid`=0.
- Back-to-back valid instructions are accepted every cycle. There is no stall and no backpressure.
- Reset asserted mid-stream clears the outputs immediately. The first valid instruction after reset deassertion is decoded normally.

## Test plan
- ADD x3,x1,x2: `instr`=002081b3 → `opcode`=0110011, `rd`=3, `rs1`=1, `rs2`=2, `funct3`=000, `funct7`=0000000, `fmt`=0, `imm`=0, `illegal`=0, `out_valid`=1 one cycle later.
- ADDI x2,x0,10: 00a00113 → `rd`=2, `rs1`=0, `imm`=0000000a, `fmt`=1. Also fff00113 → `imm`=ffffffff.
- SW / BEQ:
  - 00512023 → `rs1`=2, `rs2`=5, `imm`=00000000, `funct3`=010, `fmt`=2.
  - 00208663 → `rs1`=1, `rs2`=2, `imm`=0000000c, `fmt`=3.
  - fe208ee3 → `imm`=fffffffc.
- LUI / JAL:
  - 123450b7 → `rd`=1, `imm`=12345000, `fmt`=4.
  - 004000ef → `rd`=1, `imm`=00000004, `fmt`=5.
  - ffdff0ef → `imm`=fffffffc.
- MUL x3,x1,x2: 022081b3 → `is_muldiv`=1, `illegal`=0.
- Illegal encodings:
  - 0000007f → `illegal`=1, `fmt`=7, `imm`=0.
  - 402091b3 → `illegal`=1.
- Control:
  - `instr_valid` low for one cycle → `out_valid`=0 and outputs hold.
  - `rst_n` pulsed low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
